// File: rtl/fetch_trace_pkg.sv
// ============================================================================
// Module      : fetch_trace_pkg
// Description : Shared types and field widths for the fetch trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_trace_pkg;

    localparam int c_IR_W      = 32;
    localparam int c_COND_W    = 4;
    localparam int c_CLASS_W   = 3;
    localparam int c_NUM_CLASS = 8;
    localparam int c_META_W    = c_CLASS_W + c_COND_W + c_IR_W;

    typedef enum logic [c_CLASS_W-1:0] {
        CLS_SWAP         = 3'd0,
        CLS_DP_IMM       = 3'd1,
        CLS_DP_REG_SHIMM = 3'd2,
        CLS_DP_REG_SHREG = 3'd3,
        CLS_LOAD         = 3'd4,
        CLS_STORE        = 3'd5,
        CLS_BRANCH       = 3'd6,
        CLS_OTHER        = 3'd7
    } fclass_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_trace_buffer_if.sv
// ============================================================================
// Module      : fetch_trace_buffer_if
// Description : Fetch, trigger, readout and counter-query bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_trace_buffer_if
    import fetch_trace_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) ();

    logic [c_IR_W-1:0]        IR;
    logic                     FETCH_EN;
    logic                     ARM;
    logic                     TRIG_EN;
    logic [c_IR_W-1:0]        TRIG_MASK;
    logic [c_IR_W-1:0]        TRIG_MATCH;
    logic                     RD_VALID;
    logic                     RD_READY;
    logic [c_META_W+TS_W-1:0] RD_DATA;
    logic [1:0]               STATE;
    logic [c_CLASS_W-1:0]     CNT_SEL;
    logic [CNT_W-1:0]         CNT_OUT;

    modport master (
        output IR, FETCH_EN, ARM, TRIG_EN, TRIG_MASK, TRIG_MATCH, RD_READY, CNT_SEL,
        input  RD_VALID, RD_DATA, STATE, CNT_OUT
    );

    modport slave (
        input  IR, FETCH_EN, ARM, TRIG_EN, TRIG_MASK, TRIG_MATCH, RD_READY, CNT_SEL,
        output RD_VALID, RD_DATA, STATE, CNT_OUT
    );

endinterface

`default_nettype wire

// File: rtl/fetch_classify.sv
// ============================================================================
// Module      : fetch_classify
// Description : Combinational instruction-class decoder, first match wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_classify
    import fetch_trace_pkg::*;
(
    input  wire logic [c_IR_W-1:0] i_ir,
    output fclass_t                o_class
);

    // Condition, register and immediate fields do not take part in decode.
    logic w_unused;
    assign w_unused = ^{i_ir[31:28], i_ir[22], i_ir[19:12], i_ir[3:0]};

    always_comb begin
        o_class = CLS_OTHER;
        if ((i_ir[27:23] == 5'b00010) && (i_ir[21:20] == 2'b00) && (i_ir[11:4] == 8'b0000_1001)) begin
            o_class = CLS_SWAP;
        end else if (i_ir[27:25] == 3'b001) begin
            o_class = CLS_DP_IMM;
        end else if ((i_ir[27:25] == 3'b000) && !i_ir[4]) begin
            o_class = CLS_DP_REG_SHIMM;
        end else if (i_ir[27:25] == 3'b000) begin
            o_class = CLS_DP_REG_SHREG;
        end else if ((i_ir[27:26] == 2'b01) && i_ir[20]) begin
            o_class = CLS_LOAD;
        end else if (i_ir[27:26] == 2'b01) begin
            o_class = CLS_STORE;
        end else if (i_ir[27:25] == 3'b101) begin
            o_class = CLS_BRANCH;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_trace_buffer.sv
// ============================================================================
// Module      : fetch_trace_buffer
// Description : Circular fetch trace with trigger, post-trigger capture,
//               frozen readout and saturating per-class counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_trace_buffer
    import fetch_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int CNT_W     = 16,
    parameter int POST_TRIG = 4
) (
    input wire logic            CLK,
    input wire logic            RST,
    fetch_trace_buffer_if.slave bus
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_OCC_W     = c_PTR_W + 1;
    localparam int                 c_ENT_W     = c_META_W + TS_W;
    localparam logic [c_OCC_W-1:0] c_FULL      = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0] c_ONE_OCC   = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0] c_POST_INIT = c_PTR_W'(POST_TRIG);
    localparam logic [c_PTR_W-1:0] c_POST_LAST = c_PTR_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    state_t             r_state;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_post_cnt;
    logic [c_OCC_W-1:0] r_occ;
    logic [TS_W-1:0]    r_ts;
    logic [CNT_W-1:0]   r_cnt [c_NUM_CLASS];
    logic [c_ENT_W-1:0] r_mem [DEPTH];

    fclass_t            w_class;
    logic               w_capturing;
    logic               w_write;
    logic               w_full;
    logic               w_trig_hit;
    logic               w_rd_valid;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_entry;

    fetch_classify u_classify (
        .i_ir    (bus.IR),
        .o_class (w_class)
    );

    assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
    assign w_write     = w_capturing && bus.FETCH_EN && !bus.ARM && !RST;
    assign w_full      = (r_occ == c_FULL);
    assign w_trig_hit  = bus.TRIG_EN && ((bus.IR & bus.TRIG_MASK) == bus.TRIG_MATCH);
    assign w_rd_valid  = (r_state == ST_FROZEN) && (r_occ != '0);
    assign w_pop       = w_rd_valid && bus.RD_READY && !bus.ARM;
    assign w_entry     = {w_class, bus.IR[31:28], bus.IR, r_ts};

    // Storage is deliberately left out of reset; occupancy gates visibility.
    always_ff @(posedge CLK) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_post_cnt <= '0;
            r_occ      <= '0;
            r_ts       <= '0;
            for (int i = 0; i < c_NUM_CLASS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (bus.ARM) begin
            r_state    <= ST_CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_post_cnt <= '0;
            r_occ      <= '0;
            r_ts       <= '0;
            for (int i = 0; i < c_NUM_CLASS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + 1'b1;

            // A write into a full buffer drops the oldest entry, occupancy holds.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_full) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_occ <= r_occ + 1'b1;
                end
                if (r_cnt[w_class] != c_CNT_MAX) begin
                    r_cnt[w_class] <= r_cnt[w_class] + 1'b1;
                end
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_occ    <= r_occ - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (bus.FETCH_EN && w_trig_hit) begin
                        if (POST_TRIG == 0) begin
                            r_state <= ST_FROZEN;
                        end else begin
                            r_state    <= ST_POST;
                            r_post_cnt <= c_POST_INIT;
                        end
                    end
                end
                ST_POST: begin
                    if (bus.FETCH_EN) begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == c_POST_LAST) begin
                            r_state <= ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: begin
                    if ((r_occ == '0) || (w_pop && (r_occ == c_ONE_OCC))) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.RD_VALID = w_rd_valid;
    assign bus.RD_DATA  = r_mem[r_rd_ptr];
    assign bus.STATE    = r_state;
    assign bus.CNT_OUT  = r_cnt[bus.CNT_SEL];

endmodule

`default_nettype wire
